// File: rtl/video_fx_pkg.sv
// Shared types, palette constants and arithmetic helpers for the video
// effects controller (frame-synchronous inversion / palette scheduling).
package video_fx_pkg;

    localparam int SUM_W = 6;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        INVERT = 1'b1
    } fx_state_t;

    // RGB444 layer colours, red in [11:8], green in [7:4], blue in [3:0]
    localparam logic [11:0] PAL_STAR        = 12'h777;
    localparam logic [11:0] PAL_SAUCER_MONO = 12'h777;
    localparam logic [11:0] PAL_SAUCER_COL  = 12'h0FF;
    localparam logic [11:0] PAL_ROCKET_MONO = 12'hFFF;
    localparam logic [11:0] PAL_ROCKET_COL  = 12'hFF0;

    // Widen three 4-bit channel contributions and add them without overflow
    function automatic logic [SUM_W-1:0] add3(input logic [3:0] a,
                                              input logic [3:0] b,
                                              input logic [3:0] c);
        return {2'b00, a} + {2'b00, b} + {2'b00, c};
    endfunction

    // Clamp a channel sum to the 4-bit output range
    function automatic logic [3:0] sat4(input logic [SUM_W-1:0] s);
        logic [3:0] res;
        if (s > 6'd15) begin
            res = 4'd15;
        end else begin
            res = s[3:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fx_mixer_pipe.sv
// Two-stage pixel mixer: stage 1 sums the active layer colours, stage 2
// saturates, applies inversion and forces black during blanking.
module fx_mixer_pipe
    import video_fx_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ce_pix,
    input  logic [2:0] layers,
    input  logic       hblank,
    input  logic       vblank,
    input  logic       vsync,
    input  logic       mode_act,
    input  logic       inv,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic       hblank_o,
    output logic       vblank_o,
    output logic       vsync_o
);

    logic [11:0]      star_s;
    logic [11:0]      saucer_s;
    logic [11:0]      rocket_s;
    logic [SUM_W-1:0] r_sum_s, g_sum_s, b_sum_s;
    logic [SUM_W-1:0] r_sum_r, g_sum_r, b_sum_r;
    logic             hb1_r, vb1_r, vs1_r;
    logic [3:0]       r_nx_s, g_nx_s, b_nx_s;
    logic [3:0]       r_r, g_r, b_r;
    logic             hb2_r, vb2_r, vs2_r;

    // Select each layer's palette entry and add the channels
    always_comb begin
        star_s   = layers[0] ? PAL_STAR : 12'h000;
        saucer_s = 12'h000;
        rocket_s = 12'h000;
        if (layers[1]) begin
            saucer_s = mode_act ? PAL_SAUCER_COL : PAL_SAUCER_MONO;
        end else begin
            saucer_s = 12'h000;
        end
        if (layers[2]) begin
            rocket_s = mode_act ? PAL_ROCKET_COL : PAL_ROCKET_MONO;
        end else begin
            rocket_s = 12'h000;
        end
        r_sum_s = add3(star_s[11:8], saucer_s[11:8], rocket_s[11:8]);
        g_sum_s = add3(star_s[7:4],  saucer_s[7:4],  rocket_s[7:4]);
        b_sum_s = add3(star_s[3:0],  saucer_s[3:0],  rocket_s[3:0]);
    end

    // Stage 1: capture raw sums together with the timing bits they belong to
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sum_r <= '0;
            g_sum_r <= '0;
            b_sum_r <= '0;
            hb1_r   <= 1'b0;
            vb1_r   <= 1'b0;
            vs1_r   <= 1'b0;
        end else if (ce_pix) begin
            r_sum_r <= r_sum_s;
            g_sum_r <= g_sum_s;
            b_sum_r <= b_sum_s;
            hb1_r   <= hblank;
            vb1_r   <= vblank;
            vs1_r   <= vsync;
        end
    end

    // Saturate, invert, then let blanking override everything
    always_comb begin
        r_nx_s = 4'd0;
        g_nx_s = 4'd0;
        b_nx_s = 4'd0;
        if (hb1_r || vb1_r) begin
            r_nx_s = 4'd0;
            g_nx_s = 4'd0;
            b_nx_s = 4'd0;
        end else begin
            r_nx_s = sat4(r_sum_r) ^ {4{inv}};
            g_nx_s = sat4(g_sum_r) ^ {4{inv}};
            b_nx_s = sat4(b_sum_r) ^ {4{inv}};
        end
    end

    // Stage 2: register final pixel and the delayed timing bits
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_r   <= 4'd0;
            g_r   <= 4'd0;
            b_r   <= 4'd0;
            hb2_r <= 1'b0;
            vb2_r <= 1'b0;
            vs2_r <= 1'b0;
        end else if (ce_pix) begin
            r_r   <= r_nx_s;
            g_r   <= g_nx_s;
            b_r   <= b_nx_s;
            hb2_r <= hb1_r;
            vb2_r <= vb1_r;
            vs2_r <= vs1_r;
        end
    end

    assign r        = r_r;
    assign g        = g_r;
    assign b        = b_r;
    assign hblank_o = hb2_r;
    assign vblank_o = vb2_r;
    assign vsync_o  = vs2_r;

endmodule

// File: rtl/video_fx_ctrl.sv
// Video effects controller top: vsync edge detection, inversion scheduling
// with a minimum hold in frames, palette shadowing and a frame counter.
module video_fx_ctrl
    import video_fx_pkg::*;
#(
    parameter int INV_MIN_FRAMES = 2
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ce_pix,
    input  logic       vsync,
    input  logic       hblank,
    input  logic       vblank,
    input  logic [3:0] video,
    input  logic       color_mode,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic       hblank_o,
    output logic       vblank_o,
    output logic       vsync_o,
    output logic       inv,
    output logic [7:0] frame_cnt
);

    localparam logic [3:0] HOLD_INIT = 4'(INV_MIN_FRAMES - 1);

    logic       vsync_prev_r;
    logic       edge_s;
    logic       pend_r;
    fx_state_t  state_r, state_nx_s;
    logic [3:0] hold_r, hold_nx_s;
    logic       inv_r;
    logic       mode_act_r;
    logic [7:0] frame_cnt_r;

    assign edge_s = ce_pix & vsync & ~vsync_prev_r;

    // Next inversion state; only a frame edge can move the FSM
    always_comb begin
        state_nx_s = state_r;
        hold_nx_s  = hold_r;
        if (edge_s) begin
            if (pend_r) begin
                state_nx_s = INVERT;
                hold_nx_s  = HOLD_INIT;
            end else begin
                case (state_r)
                    INVERT: begin
                        if (hold_r != 4'd0) begin
                            hold_nx_s = hold_r - 4'd1;
                        end else begin
                            state_nx_s = NORMAL;
                        end
                    end
                    NORMAL:  state_nx_s = NORMAL;
                    default: state_nx_s = NORMAL;
                endcase
            end
        end else begin
            state_nx_s = state_r;
            hold_nx_s  = hold_r;
        end
    end

    // Frame-level state: vsync history, pending request, FSM, shadow, counter
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vsync_prev_r <= 1'b0;
            pend_r       <= 1'b0;
            state_r      <= NORMAL;
            hold_r       <= 4'd0;
            inv_r        <= 1'b0;
            mode_act_r   <= 1'b0;
            frame_cnt_r  <= 8'd0;
        end else if (ce_pix) begin
            vsync_prev_r <= vsync;
            state_r      <= state_nx_s;
            hold_r       <= hold_nx_s;
            inv_r        <= (state_nx_s == INVERT);
            if (edge_s) begin
                // a request arriving on the edge cycle is held for the new frame
                pend_r      <= video[3];
                mode_act_r  <= color_mode;
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end else begin
                pend_r <= pend_r | video[3];
            end
        end
    end

    fx_mixer_pipe u_mixer (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ce_pix   (ce_pix),
        .layers   (video[2:0]),
        .hblank   (hblank),
        .vblank   (vblank),
        .vsync    (vsync),
        .mode_act (mode_act_r),
        .inv      (inv_r),
        .r        (r),
        .g        (g),
        .b        (b),
        .hblank_o (hblank_o),
        .vblank_o (vblank_o),
        .vsync_o  (vsync_o)
    );

    assign inv       = inv_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_video_fx_ctrl.sv
// Self-checking bench for video_fx_ctrl: directed scenarios plus random
// frames, compared against a frame-level behavioural model.
module tb_video_fx_ctrl;

    localparam int INV_MIN = 2;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce_pix = 1'b0;
    logic       vsync = 1'b0;
    logic       hblank = 1'b0;
    logic       vblank = 1'b0;
    logic [3:0] video = 4'd0;
    logic       color_mode = 1'b0;
    logic [3:0] r, g, b;
    logic       hblank_o, vblank_o, vsync_o, inv;
    logic [7:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    // model state
    int  edges_m, last_apply_m;
    bit  applied_m, req_m, vs_prev_m, mode_m, inv_m;
    int  p1_r, p1_g, p1_b;
    bit  p1_hb, p1_vb, p1_vs;
    int  exp_r, exp_g, exp_b;
    bit  exp_hbo, exp_vbo, exp_vso;
    bit  cm_cur;

    video_fx_ctrl #(.INV_MIN_FRAMES(INV_MIN)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ce_pix     (ce_pix),
        .vsync      (vsync),
        .hblank     (hblank),
        .vblank     (vblank),
        .video      (video),
        .color_mode (color_mode),
        .r          (r),
        .g          (g),
        .b          (b),
        .hblank_o   (hblank_o),
        .vblank_o   (vblank_o),
        .vsync_o    (vsync_o),
        .inv        (inv),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat15(input int s);
        return (s > 15) ? 15 : s;
    endfunction

    task automatic model_reset();
        edges_m = 0; last_apply_m = 0; applied_m = 0; req_m = 0;
        vs_prev_m = 0; mode_m = 0; inv_m = 0;
        p1_r = 0; p1_g = 0; p1_b = 0; p1_hb = 0; p1_vb = 0; p1_vs = 0;
        exp_r = 0; exp_g = 0; exp_b = 0; exp_hbo = 0; exp_vbo = 0; exp_vso = 0;
    endtask

    // One pixel-enable step of the reference, using the inputs currently driven
    task automatic model_step();
        int m;
        m = inv_m ? 15 : 0;
        if (p1_hb || p1_vb) begin
            exp_r = 0; exp_g = 0; exp_b = 0;
        end else begin
            exp_r = sat15(p1_r) ^ m;
            exp_g = sat15(p1_g) ^ m;
            exp_b = sat15(p1_b) ^ m;
        end
        exp_hbo = p1_hb; exp_vbo = p1_vb; exp_vso = p1_vs;
        // layer colours straight from the palette table
        p1_r = (video[0] ? 7 : 0) + (video[1] ? (mode_m ? 0 : 7) : 0)  + (video[2] ? 15 : 0);
        p1_g = (video[0] ? 7 : 0) + (video[1] ? (mode_m ? 15 : 7) : 0) + (video[2] ? 15 : 0);
        p1_b = (video[0] ? 7 : 0) + (video[1] ? (mode_m ? 15 : 7) : 0) + (video[2] ? (mode_m ? 0 : 15) : 0);
        p1_hb = hblank; p1_vb = vblank; p1_vs = vsync;
        if (vsync && !vs_prev_m) begin
            edges_m++;
            if (req_m) begin
                applied_m    = 1;
                last_apply_m = edges_m;
            end
            mode_m = color_mode;
            req_m  = video[3];
        end else begin
            req_m = req_m | video[3];
        end
        vs_prev_m = vsync;
        inv_m = applied_m && ((edges_m - last_apply_m) < INV_MIN);
    endtask

    task automatic check_all();
        check_val("r", r, exp_r);
        check_val("g", g, exp_g);
        check_val("b", b, exp_b);
        check_val("hblank_o", hblank_o, exp_hbo);
        check_val("vblank_o", vblank_o, exp_vbo);
        check_val("vsync_o", vsync_o, exp_vso);
        check_val("inv", inv, inv_m);
        check_val("frame_cnt", frame_cnt, edges_m % 256);
    endtask

    // Three disabled clocks with junk inputs, then one enabled clock with real ones
    task automatic tick(input logic [3:0] v, input logic hb, input logic vb,
                        input logic vs, input logic cm);
        for (int i = 0; i < 3; i++) begin
            ce_pix = 1'b0;
            video = 4'($urandom); vsync = 1'($urandom); hblank = 1'($urandom);
            vblank = 1'($urandom); color_mode = 1'($urandom);
            @(posedge clk_sys); #1;
        end
        ce_pix = 1'b1; video = v; hblank = hb; vblank = vb; vsync = vs; color_mode = cm;
        model_step();
        @(posedge clk_sys); #1;
        ce_pix = 1'b0;
        check_all();
    endtask

    task automatic vs_edge(input logic [3:0] v);
        tick(v, 1'b0, 1'b0, 1'b1, cm_cur);
        tick(v, 1'b0, 1'b0, 1'b0, cm_cur);
    endtask

    task automatic do_reset();
        @(posedge clk_sys); #1;
        reset_n = 1'b0;
        model_reset();
        cm_cur = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ce_pix = 1'($urandom); video = 4'($urandom); vsync = 1'($urandom);
            @(posedge clk_sys); #1;
        end
        check_val("rst_r", r, 0);
        check_val("rst_vsync_o", vsync_o, 0);
        check_val("rst_inv", inv, 0);
        check_val("rst_frame_cnt", frame_cnt, 0);
        ce_pix = 1'b0;
        reset_n = 1'b1;
        @(posedge clk_sys); #1;
    endtask

    initial begin
        do_reset();

        // star only, mono, no blanking
        tick(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("star_r", r, 7); check_val("star_g", g, 7); check_val("star_b", b, 7);
        check_val("star_inv", inv, 0); check_val("star_fc", frame_cnt, 0);

        // all layers, mono saturates; hblank forces black two enables later
        tick(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("sat_mono_r", r, 15);
        tick(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("hblank_black", r, 0); check_val("hblank_out", hblank_o, 1);

        // one-enable request mid-frame 0 inverts for INV_MIN frames
        tick(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        vs_edge(4'b0001);
        check_val("inv_edge1", inv, 1);
        tick(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("inv_star_r", r, 8);
        vs_edge(4'b0001);
        check_val("inv_edge2", inv, 1);
        vs_edge(4'b0001);
        check_val("inv_edge3", inv, 0);

        // palette toggle waits for the next frame edge
        tick(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        cm_cur = 1'b1;
        tick(4'b0010, 1'b0, 1'b0, 1'b0, cm_cur);
        tick(4'b0010, 1'b0, 1'b0, 1'b0, cm_cur);
        check_val("col_hold_r", r, 7);
        vs_edge(4'b0010);
        tick(4'b0010, 1'b0, 1'b0, 1'b0, cm_cur);
        check_val("col_r", r, 0); check_val("col_g", g, 15); check_val("col_b", b, 15);

        // color boundaries: red 7+0+15 and blue 7+15+0 both saturate
        tick(4'b0111, 1'b0, 1'b0, 1'b0, cm_cur);
        tick(4'b0111, 1'b0, 1'b0, 1'b0, cm_cur);
        check_val("sat_col_r", r, 15); check_val("sat_col_b", b, 15);

        // request on the edge cycle belongs to the new frame
        tick(4'b1001, 1'b0, 1'b0, 1'b1, cm_cur);
        tick(4'b0001, 1'b0, 1'b0, 1'b0, cm_cur);
        check_val("edge_req_not_yet", inv, 0);
        vs_edge(4'b0001);
        check_val("edge_req_applied", inv, 1);

        // frame counter wraps after 256 edges
        do_reset();
        for (int i = 0; i < 256; i++) vs_edge({1'b0, 3'($urandom)});
        check_val("fc_wrap", frame_cnt, 0);

        // reset mid-frame discards the pending request
        tick(4'b1000, 1'b0, 1'b0, 1'b0, cm_cur);
        do_reset();
        vs_edge(4'b0001);
        check_val("rst_drops_req", inv, 0);

        // random frames
        for (int f = 0; f < 60; f++) begin
            int len;
            len = $urandom_range(2, 9);
            if ($urandom_range(0, 3) == 0) cm_cur = ~cm_cur;
            for (int p = 0; p < len; p++) begin
                logic [3:0] v;
                v = 4'($urandom);
                v[3] = ($urandom_range(0, 11) == 0);
                tick(v, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), 1'b0,
                     ($urandom_range(0, 5) == 0) ? ~cm_cur : cm_cur);
            end
            tick({($urandom_range(0, 5) == 0), 3'($urandom)}, 1'b0, 1'b1, 1'b1, cm_cur);
            tick(4'($urandom) & 4'b0111, 1'b0, 1'b1, 1'b1, cm_cur);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
